// File: rtl/counterdown16_4ch_reload_pkg.sv
// Shared defaults and lane-slicing helper for the multi-channel down-counter block.
package counterdown16_4ch_reload_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 16;
    localparam int unsigned DEFAULT_NUM_CH = 4;

    // LSB position of a channel's lane inside a flat per-channel data bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/counterdown16_4ch_reload_counterdown16.sv
// One down-counter channel: load, decrement, optional reload at zero, registered tc pulse.
module counterdown16
    import counterdown16_4ch_reload_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
        end else if (enable) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
                tc_d    = (count_q == WIDTH'(1));
            end else if (auto_reload) begin
                // A zero reload register simply keeps the count at zero, no tc.
                count_d = reload_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: rtl/counterdown16_4ch_reload.sv
// Four independent 16-bit down-counters with per-channel load and auto-reload.
module counterdown16_4ch_reload
    import counterdown16_4ch_reload_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned NUM_CH = DEFAULT_NUM_CH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_value,
    input  logic [NUM_CH-1:0]       auto_reload,
    output logic [WIDTH-1:0]        cnt0_16,
    output logic [WIDTH-1:0]        cnt1_16,
    output logic [WIDTH-1:0]        cnt2_16,
    output logic [WIDTH-1:0]        cnt3_16,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       running
);

    logic [WIDTH-1:0] count [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        counterdown16 #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk        (clock),
            .reset      (reset),
            .enable     (enable[g]),
            .load       (load[g]),
            .load_value (load_value[lane_lsb(g, WIDTH) +: WIDTH]),
            .auto_reload(auto_reload[g]),
            .count      (count[g]),
            .tc         (tc[g])
        );

        assign running[g] = (count[g] != '0);
    end

    assign cnt0_16 = count[0];
    assign cnt1_16 = count[1];
    assign cnt2_16 = count[2];
    assign cnt3_16 = count[3];

endmodule

// File: tb/tb_counterdown16_4ch_reload.sv
// Scoreboard bench: driver pushes model predictions, monitor compares after each edge.
module tb_counterdown16_4ch_reload;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  enable, load, auto_reload;
    logic [63:0] load_value;
    logic [15:0] cnt0_16, cnt1_16, cnt2_16, cnt3_16;
    logic [3:0]  tc, running;

    counterdown16_4ch_reload dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_value (load_value),
        .auto_reload(auto_reload),
        .cnt0_16    (cnt0_16),
        .cnt1_16    (cnt1_16),
        .cnt2_16    (cnt2_16),
        .cnt3_16    (cnt3_16),
        .tc         (tc),
        .running    (running)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] cnt;
        logic [3:0]  tc;
        logic [3:0]  run;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state, plain integers.
    int unsigned m_cnt [4];
    int unsigned m_rel [4];
    bit          m_tc  [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_cnt();
        return {cnt3_16, cnt2_16, cnt1_16, cnt0_16};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_rel[i] = 0;
            m_tc[i]  = 1'b0;
        end
    endfunction

    // Apply inputs, predict the state after the coming edge, push it, advance to edge+2.
    task automatic cycle(input logic [3:0] en, input logic [3:0] ld, input logic [3:0] ar,
                         input logic [63:0] lv);
        exp_t e;
        enable      = en;
        load        = ld;
        auto_reload = ar;
        load_value  = lv;
        for (int i = 0; i < 4; i++) begin
            int unsigned v;
            v = int'(lv[i*16 +: 16]);
            m_tc[i] = 1'b0;
            if (ld[i]) begin
                m_cnt[i] = v;
                m_rel[i] = v;
            end else if (en[i]) begin
                if (m_cnt[i] > 0) begin
                    m_cnt[i] = m_cnt[i] - 1;
                    m_tc[i]  = (m_cnt[i] == 0);
                end else if (ar[i]) begin
                    m_cnt[i] = m_rel[i];
                end
            end
            e.cnt[i*16 +: 16] = 16'(m_cnt[i]);
            e.tc[i]           = m_tc[i];
            e.run[i]          = (m_cnt[i] != 0);
        end
        exp_q.push_back(e);
        @(posedge clock);
        #2;
    endtask

    // Called at edge+2; fires reset between edges and checks the immediate clear.
    task automatic async_reset();
        #1;
        reset = 1'b1;
        #1;
        check("reset_async_cnt", all_cnt(), 64'h0);
        check("reset_async_tc", {60'h0, tc}, 64'h0);
        check("reset_async_running", {60'h0, running}, 64'h0);
        model_reset();
        exp_q.delete();
        @(posedge clock);
        #2;
        check("reset_held_cnt", all_cnt(), 64'h0);
        reset = 1'b0;
    endtask

    // Monitor: one prediction per edge, compared just after that edge.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_cnt", all_cnt(), e.cnt);
            check("sb_tc", {60'h0, tc}, {60'h0, e.tc});
            check("sb_running", {60'h0, running}, {60'h0, e.run});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first_tc [4];
        int pulses;
        logic [63:0] lv;

        model_reset();
        reset       = 1'b1;
        enable      = '0;
        load        = '0;
        auto_reload = '0;
        load_value  = '0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        check("post_reset_cnt", all_cnt(), 64'h0);
        check("post_reset_tc", {60'h0, tc}, 64'h0);
        check("post_reset_running", {60'h0, running}, 64'h0);

        // Channel 0: 3,2,1,0,0 holding at zero.
        cycle(4'b0000, 4'b0001, 4'b0000, 64'd3);
        check("ch0_load", {48'h0, cnt0_16}, 64'd3);
        cycle(4'b0001, 4'b0000, 4'b0000, 64'd0);
        cycle(4'b0001, 4'b0000, 4'b0000, 64'd0);
        cycle(4'b0001, 4'b0000, 4'b0000, 64'd0);
        check("ch0_zero", {48'h0, cnt0_16}, 64'd0);
        check("ch0_tc", {63'h0, tc[0]}, 64'd1);
        check("ch0_running", {63'h0, running[0]}, 64'd0);
        cycle(4'b0001, 4'b0000, 4'b0000, 64'd0);
        check("ch0_hold", {48'h0, cnt0_16}, 64'd0);
        check("ch0_tc_once", {63'h0, tc[0]}, 64'd0);

        // Channel 1: period 3 with auto-reload.
        cycle(4'b0000, 4'b0010, 4'b0010, 64'd2 << 16);
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            cycle(4'b0010, 4'b0000, 4'b0010, 64'd0);
            if (tc[1]) pulses++;
        end
        check("ch1_tc_pulses", 64'(pulses), 64'd3);
        check("ch1_reloaded", {48'h0, cnt1_16}, 64'd2);

        // Channel 2: load beats a coinciding 1->0 decrement.
        cycle(4'b0000, 4'b0100, 4'b0000, 64'd1 << 32);
        cycle(4'b0100, 4'b0100, 4'b0000, 64'h00FF << 32);
        check("ch2_load_wins", {48'h0, cnt2_16}, 64'h00FF);
        check("ch2_no_tc", {63'h0, tc[2]}, 64'd0);

        // Channel 3 mid-count, then asynchronous reset clears everything.
        cycle(4'b0000, 4'b1111, 4'b0000, {16'hFFFF, 16'd30, 16'd20, 16'd10});
        for (int k = 0; k < 3; k++) cycle(4'b1111, 4'b0000, 4'b0000, 64'd0);
        async_reset();
        cycle(4'b0000, 4'b0000, 4'b0000, 64'd0);
        check("ch3_no_tc_after_abort", {60'h0, tc}, 64'h0);

        // All channels together, enable[1] paused for two cycles.
        cycle(4'b0000, 4'b1111, 4'b0000, {16'd11, 16'd9, 16'd7, 16'd5});
        for (int i = 0; i < 4; i++) first_tc[i] = -1;
        for (int k = 1; k <= 12; k++) begin
            cycle((k == 3 || k == 4) ? 4'b1101 : 4'b1111, 4'b0000, 4'b0000, 64'd0);
            for (int i = 0; i < 4; i++) if (tc[i] && first_tc[i] < 0) first_tc[i] = k;
        end
        check("multi_tc_ch0", 64'(first_tc[0]), 64'd5);
        check("multi_tc_ch1", 64'(first_tc[1]), 64'd9);
        check("multi_tc_ch2", 64'(first_tc[2]), 64'd9);
        check("multi_tc_ch3", 64'(first_tc[3]), 64'd11);

        // Random traffic with small load values so zero, reload and tc paths get hit.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] ld;
            for (int i = 0; i < 4; i++) begin
                ld[i] = ($urandom_range(0, 7) == 0);
                lv[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                              : 16'($urandom_range(0, 6));
            end
            cycle(4'($urandom), ld, 4'($urandom), lv);
            if (n == 200) async_reset();
        end

        @(posedge clock);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
